// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchronizer, oversampled FSM, sticky ready, framing/overrun flags.
// Optional even-parity slot between data and stop when UART_RX_PARITY_EN is defined.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 clken,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [IDX_W-1:0]       bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   rx_meta, rx_s;
    logic                   stop_good, stop_bad;

    // Synchronizer flops reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep the two stages distinct flops.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_next;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) par_bit <= 1'b0;
        else        par_bit <= par_next;
    end
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        stop_good    = 1'b0;
        stop_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next     = par_bit;
`endif
        if (clken) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    // Mid start bit: a line back high means the edge was a glitch.
                    if (cnt == CNT_MID) begin
                        if (!rx_s) begin
                            state_next   = DATA;
                            cnt_next     = '0;
                            bit_idx_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_idx_next = bit_idx + IDX_ONE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        par_next   = rx_s;
                        state_next = STOP;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    // Leave mid stop bit so the next start edge is caught without slip.
                    if (cnt == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        stop_good  = rx_s;
                        stop_bad   = !rx_s;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A completing byte wins over a coincident clear; overrun uses the pre-clear rdy.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (stop_good) begin
            data_out  <= shift_reg;
            rdy       <= 1'b1;
            frame_err <= 1'b0;
            if (rdy)          overrun <= 1'b1;
            else if (rdy_clr) overrun <= 1'b0;
        end else begin
            if (stop_bad) frame_err <= 1'b1;
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    // Even parity: data bits XOR parity bit must be zero on a good frame.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)         parity_err_q <= 1'b0;
        else if (stop_good) parity_err_q <= (^shift_reg) ^ par_bit;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: tick-level line waveforms, a timing model that derives frame
// outcomes from sample positions, and a per-cycle compare against that model.
module tb_uart_receiver;

    localparam int DB      = 8;
    localparam int OS      = 16;
    localparam int HALF    = OS / 2;
    localparam int MAXT    = 4096;
`ifdef UART_RX_PARITY_EN
    localparam int SLOTS   = DB + 3;
    localparam int RISE_A5 = 172;
`else
    localparam int SLOTS   = DB + 2;
    localparam int RISE_A5 = 156;
`endif
    localparam int STOP_OFS = HALF + (SLOTS - 1) * OS;
    localparam int EV_NONE  = 0;
    localparam int EV_GOOD  = 1;
    localparam int EV_BAD   = 2;

    logic          clk_50m = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          clken;
    logic          rdy_clr;
    logic [DB-1:0] data_out;
    logic          rdy, rx_busy, frame_err, overrun, parity_err;

    uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rx        (rx),
        .clken     (clken),
        .rdy_clr   (rdy_clr),
        .data_out  (data_out),
        .rdy       (rdy),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #10 clk_50m = ~clk_50m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Line as seen by the receiver at each clken tick, plus derived outcomes per tick.
    bit         line_arr [MAXT];
    int         ev_kind  [MAXT];
    logic [7:0] ev_data  [MAXT];
    bit         ev_perr  [MAXT];
    bit         busy_arr [MAXT];
    int         line_len;
    int         cur_tick;
    int         first_rdy;
    bit         chk_en = 1'b0;

    logic [7:0] exp_data = '0;
    bit exp_rdy = 0, exp_ov = 0, exp_fe = 0, exp_pe = 0, exp_busy = 0;

    function automatic bit at(input int i);
        return (i < MAXT) ? line_arr[i] : 1'b1;
    endfunction

    task automatic new_line();
        line_len = 0;
        for (int i = 0; i < MAXT; i++) line_arr[i] = 1'b1;
    endtask

    task automatic push(input bit v, input int k);
        for (int i = 0; i < k; i++) begin
            if (line_len < MAXT) line_arr[line_len] = v;
            line_len++;
        end
    endtask

    task automatic add_frame(input logic [7:0] d, input bit stop_v, input bit par_v);
        push(1'b0, OS);
        for (int k = 0; k < DB; k++) push(d[k], OS);
`ifdef UART_RX_PARITY_EN
        push(par_v, OS);
`endif
        push(stop_v, OS);
    endtask

    // Outcome of the line: a low tick starts a frame, mid start bit must still be low,
    // then every following bit slot is read one bit period apart.
    task automatic scan();
        int t, t0, ts;
        logic [7:0] d;
        for (int i = 0; i < MAXT; i++) begin
            ev_kind[i] = EV_NONE; ev_data[i] = '0; ev_perr[i] = 1'b0; busy_arr[i] = 1'b0;
        end
        t = 0;
        while (t < line_len) begin
            if (at(t)) begin
                t++;
            end else begin
                t0 = t;
                if (at(t0 + HALF)) begin
                    for (int i = t0; i < t0 + HALF && i < MAXT; i++) busy_arr[i] = 1'b1;
                    t = t0 + HALF + 1;
                end else begin
                    d = '0;
                    for (int k = 0; k < DB; k++) d[k] = at(t0 + HALF + (k + 1) * OS);
                    ts = t0 + STOP_OFS;
                    for (int i = t0; i < ts && i < MAXT; i++) busy_arr[i] = 1'b1;
                    if (ts < MAXT) begin
                        ev_kind[ts] = at(ts) ? EV_GOOD : EV_BAD;
                        ev_data[ts] = d;
`ifdef UART_RX_PARITY_EN
                        ev_perr[ts] = (^d) ^ at(t0 + HALF + (DB + 1) * OS);
`endif
                    end
                    t = ts + 1;
                end
            end
        end
    endtask

    // Output model: tick outcomes applied to the sticky flags, clear honoured every clock.
    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            exp_data <= '0; exp_rdy <= 0; exp_ov <= 0; exp_fe <= 0; exp_pe <= 0; exp_busy <= 0;
        end else begin
            if (clken && ev_kind[cur_tick] == EV_GOOD) begin
                exp_ov   <= exp_rdy ? 1'b1 : (rdy_clr ? 1'b0 : exp_ov);
                exp_rdy  <= 1'b1;
                exp_data <= ev_data[cur_tick];
                exp_fe   <= 1'b0;
                exp_pe   <= ev_perr[cur_tick];
            end else begin
                if (clken && ev_kind[cur_tick] == EV_BAD) exp_fe <= 1'b1;
                if (rdy_clr) begin
                    exp_rdy <= 1'b0;
                    exp_ov  <= 1'b0;
                end
            end
            if (clken) exp_busy <= busy_arr[cur_tick];
        end
    end

    always @(negedge clk_50m) begin
        if (chk_en) begin
            check("data_out",   data_out,   exp_data);
            check("rdy",        rdy,        exp_rdy);
            check("rx_busy",    rx_busy,    exp_busy);
            check("frame_err",  frame_err,  exp_fe);
            check("overrun",    overrun,    exp_ov);
            check("parity_err", parity_err, exp_pe);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    // One tick per 4 clocks; rx changes exactly two clocks before the tick edge.
    task automatic run_line(input int from, input int to, input bit rand_clr);
        for (int t = from; t < to; t++) begin
            int slot;
            slot = -1;
            if (rand_clr) begin
                int r;
                r = $urandom_range(0, 23);
                if (r < 4) slot = r;
            end
            for (int c = 0; c < 4; c++) begin
                clken    = (c == 3);
                rdy_clr  = (c == slot);
                cur_tick = t;
                if (c == 1) rx = line_arr[t];
                wait_clk(1);
            end
            if (rdy === 1'b1 && first_rdy < 0) first_rdy = t;
        end
        clken   = 1'b0;
        rdy_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        wait_clk(1);
        rdy_clr = 1'b0;
    endtask

    task automatic run_simple(input logic [7:0] d, input bit stop_v, input bit par_v);
        new_line();
        push(1'b1, 4);
        add_frame(d, stop_v, par_v);
        push(1'b1, 20);
        scan();
        first_rdy = -1;
        run_line(0, line_len, 1'b0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx = 1'b1; clken = 1'b0; rdy_clr = 1'b0; cur_tick = 0; first_rdy = -1;
        new_line();
        scan();
        wait_clk(3);
        check("reset data_out", data_out, 0);
        check("reset rdy", rdy, 0);
        check("reset rx_busy", rx_busy, 0);
        check("reset flags", {frame_err, overrun, parity_err}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        wait_clk(2);

        // 0xA5: rdy rises after the stop-sample tick
        run_simple(8'hA5, 1'b1, 1'b0);
        check("a5 rise tick", first_rdy, RISE_A5);
        check("a5 data", data_out, 8'hA5);
        check("a5 rdy", rdy, 1);
        check("a5 fe/ov", {frame_err, overrun}, 0);
        pulse_clr();

        // 3-tick glitch is rejected at the start check
        new_line();
        push(1'b1, 4); push(1'b0, 3); push(1'b1, 20);
        scan();
        run_line(0, line_len, 1'b0);
        check("glitch rdy", rdy, 0);
        check("glitch fe", frame_err, 0);
        check("glitch busy", rx_busy, 0);

        // bad stop keeps data, next good frame clears frame_err
        run_simple(8'h3C, 1'b0, 1'b0);
        check("bad stop fe", frame_err, 1);
        check("bad stop rdy", rdy, 0);
        check("bad stop data", data_out, 8'hA5);
        run_simple(8'h55, 1'b1, 1'b0);
        check("good 55 fe", frame_err, 0);
        check("good 55 data", data_out, 8'h55);
        pulse_clr();

        // back-to-back frames overrun
        new_line();
        push(1'b1, 4);
        add_frame(8'h01, 1'b1, 1'b1);
        add_frame(8'hFE, 1'b1, 1'b1);
        push(1'b1, 12);
        scan();
        run_line(0, line_len, 1'b0);
        check("b2b data", data_out, 8'hFE);
        check("b2b rdy", rdy, 1);
        check("b2b overrun", overrun, 1);

        // reset in the middle of DATA
        new_line();
        push(1'b1, 4);
        add_frame(8'h77, 1'b1, 1'b0);
        push(1'b1, 12);
        scan();
        run_line(0, 4 + HALF + 4 * OS, 1'b0);
        check("mid busy", rx_busy, 1);
        #5 rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("rst data", data_out, 0);
        check("rst rdy/ov", {rdy, overrun}, 0);
        check("rst busy", rx_busy, 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        run_simple(8'h12, 1'b1, 1'b0);
        check("after rst data", data_out, 8'h12);
        check("after rst rdy/ov", {rdy, overrun}, 2'b10);
        run_simple(8'h34, 1'b1, 1'b0);
        check("second overrun", overrun, 1);
        pulse_clr();
        check("clr rdy/ov", {rdy, overrun}, 0);

`ifdef UART_RX_PARITY_EN
        run_simple(8'h07, 1'b1, 1'b1);
        check("par ok rdy", rdy, 1);
        check("par ok perr", parity_err, 0);
        pulse_clr();
        run_simple(8'h07, 1'b1, 1'b0);
        check("par bad rdy", rdy, 1);
        check("par bad perr", parity_err, 1);
        check("par bad rise", first_rdy, 172);
        pulse_clr();
`endif

        // line stuck low: repeated framing errors, no rdy
        new_line();
        push(1'b1, 4); push(1'b0, 320); push(1'b1, 200);
        scan();
        run_line(0, 324, 1'b0);
        check("stuck fe", frame_err, 1);
        check("stuck rdy", rdy, 0);
        run_line(324, line_len, 1'b0);
        pulse_clr();

        // randomized frames, glitches, bad stops and clears
        for (int p = 0; p < 4; p++) begin
            new_line();
            push(1'b1, 2 + $urandom_range(0, 5));
            for (int f = 0; f < 10; f++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    push(1'b0, $urandom_range(1, 10));
                    push(1'b1, 10);
                end else if (r == 1) begin
                    add_frame(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
                    push(1'b1, $urandom_range(0, 20));
                end else begin
                    add_frame(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)));
                    push(1'b1, $urandom_range(0, 8));
                end
            end
            push(1'b1, 200);
            scan();
            run_line(0, line_len, 1'b1);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage, directly downstream of the transmitter. Consumes the `Tx` line of a far-end transmitter (8N1, LSB first, idle high).
- Runs on `clk_50m`. Samples the line on a 16x-baud enable pulse from the shared baud generator.
- Delivers each received byte with a sticky ready flag, cleared by the consumer.
- Reports framing and overrun errors.

Parameters:
- `DATA_BITS`, 8: data bits per frame. Legal range 5..8.
- `OVERSAMPLE`, 16: `clken` ticks per bit period. Must be even, >= 4.

Ports:
- `clk_50m`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `rx`, input, 1: serial line, asynchronous to `clk_50m`.
- `clken`, input, 1: 1-cycle pulse at `OVERSAMPLE` x baud rate.
- `rdy_clr`, input, 1: consumer acknowledge. While high, clears `rdy` and `overrun`.
- `data_out`, output, `DATA_BITS`: last good received byte.
- `rdy`, output, 1: `data_out` holds a new byte.
- `rx_busy`, output, 1: high whenever the FSM is not in IDLE.
- `frame_err`, output, 1: stop bit of the last frame sampled low.
- `overrun`, output, 1: a new byte completed while `rdy` was still 1.
- `parity_err`, output, 1: parity mismatch. Tied 0 unless the macro is defined.

Behaviour:
- Clock and reset:
  - One clock, `clk_50m`. Reset is asynchronous and active-low, on `rst_n`.
  - All state advances only on `clk_50m` edges where `clken` = 1, except the synchronizer, the `rdy`/`overrun` clear, and reset.
- Reset values:
  - `data_out` = 0, `rdy` = 0, `rx_busy` = 0, `frame_err` = 0, `overrun` = 0, `parity_err` = 0.
  - FSM in IDLE; sample counter = 0; bit index = 0.
  - Synchronizer flops = 1 (line idle).
  - Reset mid-frame abandons the frame with no output update.
- Input path: `rx` passes through a 2-flop synchronizer (`rx_s`) on every clock. The FSM sees only `rx_s`.
- Sample counter: width clog2(`OVERSAMPLE`). Bit index: 0..`DATA_BITS`-1.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - On `clken` with `rx_s` = 0: go to START, counter <= 0.
- START:
  - On `clken`: if counter == `OVERSAMPLE`/2-1, check the line; otherwise counter++.
  - At the check, `rx_s` = 0: go to DATA, counter <= 0, bit index <= 0.
  - At the check, `rx_s` = 1 (glitch / false start): return to IDLE. No flags change.
- DATA:
  - On `clken`: if counter == `OVERSAMPLE`-1, shift `rx_s` into the shift register (LSB first) and set counter <= 0; otherwise counter++.
  - After bit `DATA_BITS`-1 is sampled: go to STOP (or PARITY if enabled).
- STOP:
  - Sample at counter == `OVERSAMPLE`-1, then return to IDLE immediately (mid stop bit) so back-to-back frames resync.
  - `rx_s` = 1: `data_out` <= shift register, `rdy` <= 1, `frame_err` <= 0. If `rdy` was already 1, `overrun` <= 1 and `data_out` is overwritten.
  - `rx_s` = 0: `frame_err` <= 1. `data_out` and `rdy` are unchanged.
- Timing, with the falling edge detected at tick T0:
  - Start bit is checked at T0+`OVERSAMPLE`/2.
  - Data bit k is sampled at T0+`OVERSAMPLE`/2+(k+1)·`OVERSAMPLE`.
  - The stop bit is sampled at the next bit slot. For defaults, this is T152.
  - `rdy` is high on the clock after T152.
  - Line-to-FSM latency is 2 clocks.
- `rdy` / `overrun` clear:
  - `rdy_clr` = 1 clears both on the next clock, independent of `clken`.
  - If `rdy_clr` coincides with a byte completion, the set wins: `rdy` = 1. `overrun` takes the completion-time value computed from the old `rdy`.
- `rx_busy`: combinational, (state != IDLE).
- A `rx` held low continuously produces repeated framing errors and no `rdy`.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- When defined:
  - A PARITY state is inserted between DATA and STOP, with one extra bit slot sampled at counter == `OVERSAMPLE`-1.
  - Parity is even: XOR of the data bits and the parity bit must be 0.
  - `parity_err` is updated on every frame that reaches STOP with a valid stop bit; `rdy` is still set on a parity error.
  - The stop sample moves one bit later: T168 for defaults.
- When undefined:
  - No PARITY state exists and `parity_err` is constant 0.

Test Plan:
- 8N1 byte 0xA5 with `clken` every 4 clocks -> `rdy` rises on the clock after tick T152; `data_out` = 0xA5; `frame_err` = 0, `overrun` = 0.
- `rx` low pulse of 3 ticks, then high -> FSM returns to IDLE at the start check; `rdy` = 0, `frame_err` = 0; `rx_busy` deasserts.
- Frame 0x3C with stop bit driven 0 -> `frame_err` = 1, `rdy` = 0, `data_out` keeps its previous value. A following good frame 0x55 -> `frame_err` = 0, `data_out` = 0x55.
- Two back-to-back frames 0x01, 0xFE with no `rdy_clr` -> `data_out` = 0xFE, `rdy` = 1, `overrun` = 1. Then `rdy_clr` pulse -> both flags 0 on the next clock.
- `rst_n` asserted mid-DATA of frame 0x77 -> all outputs go to reset values immediately. After release, the next frame 0x12 is received correctly.
- With `UART_RX_PARITY_EN` defined: 0x07 with parity bit 1 -> `rdy` = 1, `parity_err` = 0. Same byte with parity bit 0 -> `rdy` = 1, `parity_err` = 1, stop sampled at T168.
